// File: rtl/hamm_cmd_ctrl_if.sv
// UART-facing link of the Hamming command controller: the received-byte side
// from uart_rx and the reply side towards uart_tx.
interface hamm_cmd_ctrl_if;
  logic [7:0] data_received;
  logic       rx_done;
  logic       parity_error;
  logic       tx_busy;
  logic [7:0] data_to_tx;
  logic       start_tx;

  // UART side: delivers received bytes and transmitter status, takes replies.
  modport master (
    output data_received, rx_done, parity_error, tx_busy,
    input  data_to_tx, start_tx
  );

  // Controller side.
  modport slave (
    input  data_received, rx_done, parity_error, tx_busy,
    output data_to_tx, start_tx
  );
endinterface

// File: rtl/hamm_cmd_ctrl.sv
// Command controller: decodes each received byte as an extended Hamming(8,4)
// SECDED codeword, executes the 4-bit command on a registered enable, sends a
// one-byte status reply and drops the enable when the watchdog expires.
module hamm_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 12_000_000
) (
  input  logic           clk,
  input  logic           reset,
  hamm_cmd_ctrl_if.slave bus,
  output logic           enable,
  output logic           cmd_valid,
  output logic [3:0]     cmd_code,
  output logic           corrected,
  output logic [7:0]     err_count
);

  typedef enum logic [2:0] {
    IDLE, DECODE, EXEC, SEND, WAIT_HI, WAIT_LO
  } state_t;

  localparam bit          WD_ON   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nx;

  logic [7:0]  byte_q;
  logic        perr_q;
  logic [2:0]  syn_q;
  logic        par_q;
  logic [3:0]  nib_q;
  logic [1:0]  hi_cnt;
  logic [31:0] wd_cnt;
  logic [7:0]  tx_q;
  logic        start_q;

  logic [2:0]  syn_c;
  logic        par_c;
  logic [3:0]  nib_c;

  logic        cmd_known;
  logic [1:0]  err_code;
  logic        accept;
  logic        fixed;
  logic        en_cmd;

  logic        exec_ok;
  logic        exec_rej;
  logic        overrun;
  logic        start_d;
  logic [1:0]  err_inc;
  logic [8:0]  err_sum;

  assign bus.data_to_tx = tx_q;
  assign bus.start_tx   = start_q;

  // Syndrome, overall parity and single-error-corrected data nibble of the captured byte.
  always_comb begin
    syn_c[0] = byte_q[0] ^ byte_q[2] ^ byte_q[4] ^ byte_q[6];
    syn_c[1] = byte_q[1] ^ byte_q[2] ^ byte_q[5] ^ byte_q[6];
    syn_c[2] = byte_q[3] ^ byte_q[4] ^ byte_q[5] ^ byte_q[6];
    par_c    = ^byte_q;
    // Only data positions 3,5,6,7 matter for the nibble; a parity-position
    // syndrome leaves the data untouched.
    nib_c    = {byte_q[6] ^ (syn_c == 3'd7),
                byte_q[5] ^ (syn_c == 3'd6),
                byte_q[4] ^ (syn_c == 3'd5),
                byte_q[2] ^ (syn_c == 3'd3)};
  end

  // Classify the decoded byte: error code (0 = accepted), correction flag, new enable.
  always_comb begin
    cmd_known = (nib_q == 4'h6) || (nib_q == 4'hD) || (nib_q == 4'h9) || (nib_q == 4'h0);
    err_code  = 2'd0;
    if (perr_q)
      err_code = 2'd1;
    else if ((syn_q != '0) && !par_q)
      err_code = 2'd2;
    else if (!cmd_known)
      err_code = 2'd3;
    accept = (err_code == 2'd0);
    fixed  = (syn_q != '0) || par_q;
    case (nib_q)
      4'h6:    en_cmd = 1'b1;
      4'hD:    en_cmd = 1'b0;
      4'h9:    en_cmd = ~enable;
      default: en_cmd = enable;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.rx_done) state_nx = DECODE;
      DECODE:  state_nx = EXEC;
      EXEC:    state_nx = SEND;
      SEND:    if (!bus.tx_busy) state_nx = WAIT_HI;
      WAIT_HI: begin
        if (bus.tx_busy)
          state_nx = WAIT_LO;
        else if (hi_cnt == 2'd3)
          state_nx = IDLE;
      end
      WAIT_LO: if (!bus.tx_busy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode: execute/reject strobes, transmit request, error increment.
  always_comb begin
    exec_ok  = (state == EXEC) && accept;
    exec_rej = (state == EXEC) && !accept;
    overrun  = bus.rx_done && (state != IDLE);
    start_d  = (state == SEND) && !bus.tx_busy;
    // A rejection and an overrun can land in the same cycle, hence +2.
    err_inc  = {1'b0, exec_rej} + {1'b0, overrun};
    err_sum  = {1'b0, err_count} + {7'd0, err_inc};
  end

  // Byte capture and decode pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_q <= '0;
      perr_q <= 1'b0;
      syn_q  <= '0;
      par_q  <= 1'b0;
      nib_q  <= '0;
    end else begin
      if ((state == IDLE) && bus.rx_done) begin
        byte_q <= bus.data_received;
        perr_q <= bus.parity_error;
      end
      if (state == DECODE) begin
        syn_q <= syn_c;
        par_q <= par_c;
        nib_q <= nib_c;
      end
    end
  end

  // Command results, reply byte, transmit strobe, error counter, busy-wait timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_valid <= 1'b0;
      corrected <= 1'b0;
      cmd_code  <= '0;
      tx_q      <= '0;
      start_q   <= 1'b0;
      err_count <= '0;
      hi_cnt    <= '0;
    end else begin
      cmd_valid <= exec_ok;
      corrected <= exec_ok && fixed;
      start_q   <= start_d;
      if (exec_ok)
        cmd_code <= nib_q;
      if (state == EXEC)
        tx_q <= accept ? {4'hA, nib_q} : {4'hE, 2'b00, err_code};
      err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
      hi_cnt    <= (state == WAIT_HI) ? hi_cnt + 2'd1 : '0;
    end
  end

  // Enable and watchdog; an executed command takes priority over a same-cycle timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable <= 1'b0;
      wd_cnt <= '0;
    end else if (exec_ok) begin
      enable <= en_cmd;
      wd_cnt <= '0;
    end else if (!enable) begin
      wd_cnt <= '0;
    end else if (WD_ON && (wd_cnt == WD_LAST)) begin
      enable <= 1'b0;
      wd_cnt <= '0;
    end else if (WD_ON) begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hamm_cmd_ctrl.sv
// Directed bench for hamm_cmd_ctrl: a vector table of codewords with
// hand-computed replies, followed by watchdog, busy-stall/overrun and
// mid-reply reset sequences.
module tb_hamm_cmd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable, cmd_valid, corrected;
  logic [3:0] cmd_code;
  logic [7:0] err_count;
  logic       hold_busy = 1'b0;
  int         busy_left = 0;

  int n_assert = 0;
  int n_fail   = 0;

  // monitor counters
  int         reply_cnt  = 0;
  int         valid_cnt  = 0;
  int         corr_cnt   = 0;
  int         dbl_start  = 0;
  int         corr_alone = 0;
  logic [7:0] last_reply = 8'h00;
  logic       prev_start = 1'b0;

  always #5 clk = ~clk;

  hamm_cmd_ctrl_if bus();

  assign bus.tx_busy = (busy_left != 0) || hold_busy;

  hamm_cmd_ctrl #(.TIMEOUT_CYCLES(100)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .enable    (enable),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .corrected (corrected),
    .err_count (err_count)
  );

  // uart_tx stand-in: busy for 5 cycles after each transmit request
  always @(negedge clk) begin
    if (bus.start_tx) busy_left = 5;
    else if (busy_left != 0) busy_left = busy_left - 1;
  end

  // pulse / reply monitor
  always @(negedge clk) begin
    if (bus.start_tx) begin
      reply_cnt  = reply_cnt + 1;
      last_reply = bus.data_to_tx;
    end
    if (bus.start_tx && prev_start) dbl_start = dbl_start + 1;
    prev_start = bus.start_tx;
    if (cmd_valid) valid_cnt = valid_cnt + 1;
    if (corrected) corr_cnt = corr_cnt + 1;
    if (corrected && !cmd_valid) corr_alone = corr_alone + 1;
  end

  typedef struct {
    logic [7:0] rx;
    logic       perr;
    logic [7:0] reply;
    logic       en;
    logic [3:0] code;
    logic       valid;
    logic       corr;
    logic [7:0] errs;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert = n_assert + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic p);
    bus.data_received = b;
    bus.parity_error  = p;
    bus.rx_done       = 1'b1;
    tick();
    bus.rx_done       = 1'b0;
    bus.parity_error  = 1'b0;
  endtask

  task automatic wait_reply(input int base);
    int k;
    k = 0;
    while ((reply_cnt == base) && (k < 200)) begin
      tick();
      k++;
    end
    repeat (12) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " data_to_tx"}, 32'(bus.data_to_tx), 32'h0);
    check({tag, " start_tx"},   32'(bus.start_tx),   32'h0);
    check({tag, " enable"},     32'(enable),         32'h0);
    check({tag, " cmd_valid"},  32'(cmd_valid),      32'h0);
    check({tag, " cmd_code"},   32'(cmd_code),       32'h0);
    check({tag, " corrected"},  32'(corrected),      32'h0);
    check({tag, " err_count"},  32'(err_count),      32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int rb, vb, cb, k;
    bit found;

    // rx, perr, reply, enable, cmd_code, valid pulses, corrected pulses, err_count
    vecs[0]  = '{8'h33, 1'b0, 8'hA6, 1'b1, 4'h6, 1'b1, 1'b0, 8'd0};
    vecs[1]  = '{8'h37, 1'b0, 8'hA6, 1'b1, 4'h6, 1'b1, 1'b1, 8'd0};
    vecs[2]  = '{8'h30, 1'b0, 8'hE2, 1'b1, 4'h6, 1'b0, 1'b0, 8'd1};
    vecs[3]  = '{8'h66, 1'b0, 8'hAD, 1'b0, 4'hD, 1'b1, 1'b0, 8'd1};
    vecs[4]  = '{8'h33, 1'b1, 8'hE1, 1'b0, 4'hD, 1'b0, 1'b0, 8'd2};
    vecs[5]  = '{8'hCC, 1'b0, 8'hA9, 1'b1, 4'h9, 1'b1, 1'b0, 8'd2};
    vecs[6]  = '{8'hB3, 1'b0, 8'hA6, 1'b1, 4'h6, 1'b1, 1'b1, 8'd2};
    vecs[7]  = '{8'h87, 1'b0, 8'hE3, 1'b1, 4'h6, 1'b0, 1'b0, 8'd3};
    vecs[8]  = '{8'h4C, 1'b0, 8'hA9, 1'b0, 4'h9, 1'b1, 1'b1, 8'd3};
    vecs[9]  = '{8'h00, 1'b0, 8'hA0, 1'b0, 4'h0, 1'b1, 1'b0, 8'd3};
    vecs[10] = '{8'hCD, 1'b0, 8'hA9, 1'b1, 4'h9, 1'b1, 1'b1, 8'd3};
    vecs[11] = '{8'h26, 1'b0, 8'hAD, 1'b0, 4'hD, 1'b1, 1'b1, 8'd3};

    reset             = 1'b0;
    bus.rx_done       = 1'b0;
    bus.data_received = 8'h00;
    bus.parity_error  = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b1;
    repeat (2) tick();

    // table-driven codewords
    for (int i = 0; i < 12; i++) begin
      rb = reply_cnt;
      vb = valid_cnt;
      cb = corr_cnt;
      send_byte(vecs[i].rx, vecs[i].perr);
      wait_reply(rb);
      check($sformatf("v%0d reply_count", i), 32'(reply_cnt - rb), 32'd1);
      check($sformatf("v%0d reply", i),       32'(last_reply),     32'(vecs[i].reply));
      check($sformatf("v%0d enable", i),      32'(enable),         32'(vecs[i].en));
      check($sformatf("v%0d cmd_code", i),    32'(cmd_code),       32'(vecs[i].code));
      check($sformatf("v%0d cmd_valid", i),   32'(valid_cnt - vb), 32'(vecs[i].valid));
      check($sformatf("v%0d corrected", i),   32'(corr_cnt - cb),  32'(vecs[i].corr));
      check($sformatf("v%0d err_count", i),   32'(err_count),      32'(vecs[i].errs));
    end

    // exact EXEC timing and watchdog expiry 100 cycles after the EXEC edge
    rb = reply_cnt;
    send_byte(8'h33, 1'b0);
    tick();
    check("wd exec_not_early", 32'(cmd_valid), 32'd0);
    tick();
    check("wd cmd_valid_at_exec", 32'(cmd_valid),      32'd1);
    check("wd enable_at_exec",    32'(enable),         32'd1);
    check("wd data_at_exec",      32'(bus.data_to_tx), 32'hA6);
    tick();
    check("wd start_tx_earliest", 32'(bus.start_tx),   32'd1);
    repeat (98) tick();
    check("wd enable_before_timeout", 32'(enable), 32'd1);
    tick();
    check("wd enable_at_timeout", 32'(enable), 32'd0);
    repeat (10) tick();
    check("wd reply_count", 32'(reply_cnt - rb), 32'd1);
    check("wd err_count",   32'(err_count),      32'd3);

    // tx_busy held for 50 cycles after EXEC, with an overrun byte in between
    rb = reply_cnt;
    hold_busy = 1'b1;
    send_byte(8'h00, 1'b0);
    repeat (2) tick();
    repeat (10) tick();
    send_byte(8'h33, 1'b0);
    repeat (39) tick();
    check("stall no_start",     32'(reply_cnt - rb), 32'd0);
    check("stall overrun_err",  32'(err_count),      32'd4);
    hold_busy = 1'b0;
    wait_reply(rb);
    check("stall reply_count",  32'(reply_cnt - rb), 32'd1);
    check("stall reply",        32'(last_reply),     32'hA0);
    check("stall dropped_byte", 32'(enable),         32'd0);
    check("stall cmd_code",     32'(cmd_code),       32'h0);
    check("stall err_count",    32'(err_count),      32'd4);

    // reset asserted while start_tx is high
    send_byte(8'h33, 1'b0);
    found = 1'b0;
    k = 0;
    while (!found && (k < 50)) begin
      tick();
      if (bus.start_tx) found = 1'b1;
      k++;
    end
    check("rst start_tx_seen", 32'(found),  32'd1);
    check("rst enable_before", 32'(enable), 32'd1);
    reset = 1'b0;
    #1;
    check_all_zero("rst mid_reply");
    repeat (3) tick();
    reset = 1'b1;
    tick();
    rb = reply_cnt;
    send_byte(8'h33, 1'b0);
    wait_reply(rb);
    check("post_rst reply_count", 32'(reply_cnt - rb), 32'd1);
    check("post_rst reply",       32'(last_reply),     32'hA6);
    check("post_rst enable",      32'(enable),         32'd1);
    check("post_rst err_count",   32'(err_count),      32'd0);

    check("start_tx back_to_back",    32'(dbl_start),  32'd0);
    check("corrected without_valid",  32'(corr_alone), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hamm_cmd_ctrl.md
# hamm_cmd_ctrl

Command controller directly downstream of `uart_rx` and upstream of `uart_tx` in the FPGA command link. It takes each received byte as an extended Hamming(8,4) SECDED codeword, corrects single-bit errors, rejects double-bit errors, and executes the 4-bit command on a registered output-enable. Every byte it accepts gets a one-byte status reply through `uart_tx`. A watchdog drops the enable if no valid command arrives within a set window.

## Interface
- `TIMEOUT_CYCLES`, default 12_000_000: watchdog window in `clk` cycles; 1 s at 12 MHz. 0 disables the watchdog.
- `clk`  in  1  system clock (12 MHz HFOSC).
- `reset`  in  1  asynchronous, active-low reset.
- `data_received`  in  8  byte from `uart_rx`; valid in the cycle `rx_done`=1.
- `rx_done`  in  1  one-cycle pulse: new byte available.
- `parity_error`  in  1  UART parity flag; qualified by `rx_done`.
- `tx_busy`  in  1  `uart_tx` busy.
- `data_to_tx`  out  8  reply byte; stable from the `start_tx` cycle until the wait state ends.
- `start_tx`  out  1  one-cycle transmit request.
- `enable`  out  1  commanded output state (1 = on).
- `cmd_valid`  out  1  one-cycle pulse: command executed.
- `cmd_code`  out  4  last executed command nibble.
- `corrected`  out  1  one-cycle pulse with `cmd_valid`; a single-bit error was fixed.
- `err_count`  out  8  saturating count of rejected or dropped bytes.

## Operation
- **Reset values.** All outputs are 0. State is IDLE and the watchdog counter is 0.
- **Codeword layout.** Bits [6:0] are Hamming positions 1..7: p1, p2, d1, p4, d2, d3, d4. Bit 7 is overall even parity across all 8 bits. The data nibble is {d4, d3, d2, d1}.
- **Syndrome.**
  - s1 = c1^c3^c5^c7
  - s2 = c2^c3^c6^c7
  - s4 = c4^c5^c6^c7
  - P = XOR of all 8 bits.
- **Classification.**
  - s=0, P=0: clean.
  - s≠0, P=1: flip position s, then treat as clean and set `corrected`.
  - s=0, P=1: bit 7 was in error; data is used unchanged and `corrected` is set.
  - s≠0, P=0: uncorrectable, error code 2.
  - `parity_error`=1 overrides all of the above with error code 1.
- **Commands.**
  - 4'h6: `enable`←1.
  - 4'hD: `enable`←0.
  - 4'h9: `enable`←~`enable`.
  - 4'h0: ping, no change.
  - Any other nibble: error code 3.
- **Replies.**
  - Valid command: {4'hA, cmd}.
  - Rejected byte: {4'hE, err}.
  - A rejected byte increments `err_count` (saturating at 8'hFF) and leaves `enable` and `cmd_code` unchanged.
- **States.**
  - IDLE: on `rx_done`, capture the byte and flag, go to DECODE.
  - DECODE: register the syndrome, parity and corrected nibble, go to EXEC.
  - EXEC: apply the command, pulse `cmd_valid`/`corrected`, load `data_to_tx`, go to SEND.
  - SEND: when `tx_busy`=0, pulse `start_tx` and go to WAIT_HI.
  - WAIT_HI: on `tx_busy`=1 go to WAIT_LO; if busy is not seen within 4 cycles, go to IDLE.
  - WAIT_LO: on `tx_busy`=0 go to IDLE.
- **Overrun.** An `rx_done` pulse in any state other than IDLE drops that byte and increments `err_count`. No reply is sent for it.
- **Watchdog.**
  - The counter clears on every executed valid command (including ping) and whenever `enable`=0.
  - While `enable`=1 it counts. Reaching `TIMEOUT_CYCLES` forces `enable`←0 and clears the counter. No reply is sent.
  - If a valid command executes in the same cycle as the timeout, the command wins.
- **Reset mid-operation.** Reset aborts any reply immediately: `start_tx`=0 and the state returns to IDLE.

## Timing
- Call the edge that samples `rx_done`=1 edge E.
- DECODE occupies cycle E+1. EXEC updates `enable`, `cmd_code` and `data_to_tx` at edge E+2. The `cmd_valid`/`corrected` pulse is high from E+2 to E+3.
- `start_tx` rises at edge E+3 at the earliest, and later if `tx_busy` is held high.
- Minimum accepted byte spacing equals the reply duration plus 4 cycles. At 6 Mbaud the UART framing keeps this from being the bottleneck.
- `start_tx` is never high for two consecutive cycles.

## Test plan
- Release reset, send byte 0x33 with no parity error. Required: `enable`=1, `cmd_code`=6, one `cmd_valid` pulse, reply 0xA6, `err_count`=0.
- Send 0x37 (0x33 with bit 2 flipped). Required: `enable`=1, `corrected` pulse, reply 0xA6.
- Send 0x30 (double error). Required: `enable` unchanged, reply 0xE2, `err_count`+1.
- With `enable`=1, send 0x66, then 0x33 with `parity_error`=1. Required: `enable`=0 after 0x66 with reply 0xAD; the second byte gives reply 0xE1 and `enable` stays 0.
- Hold `tx_busy`=1 for 50 cycles after EXEC while pulsing `rx_done` once more. Required: `start_tx` is delayed until busy falls, the extra byte is dropped, `err_count`+1, exactly one reply.
- Set `TIMEOUT_CYCLES`=100, send 0x33, then stay idle. Required: `enable` falls exactly 100 cycles after the EXEC edge. Repeat with reset asserted mid-reply: all outputs go to 0 immediately.
